wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_arb2_mux.sv | 15 +
 rtl/wb_arb2.sv | 82 ++++++++
 tb/tb_wb_arb2.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone-style arbiter.
package wb_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

endpackage

// File: rtl/wb_arb2_mux.sv
// Parameterised 2:1 payload multiplexer.
module wb_arb2_mux #(
    parameter int WIDTH = 16
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-requester round-robin arbiter feeding a single registered output slot,
// with per-requester grant counters.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNTW-1:0]  gnt_cnt0,
    output logic [CNTW-1:0]  gnt_cnt1
);

    state_t           state, state_nxt;
    logic             prio;
    logic             accept;
    logic             gnt0, gnt1, gnt_any;
    logic [WIDTH-1:0] sel_data;

    always_comb begin
        state_nxt = state;
        accept    = (state == EMPTY) || out_ready;
        gnt0      = accept && req0_valid && (!req1_valid || (prio == SRC_0));
        gnt1      = accept && req1_valid && (!req0_valid || (prio == SRC_1));
        gnt_any   = gnt0 || gnt1;
        if (gnt_any) begin
            state_nxt = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Ready is masked by reset: state is already EMPTY then, so accept alone would leak.
    assign req0_ready = gnt0 && rst_n;
    assign req1_ready = gnt1 && rst_n;
    assign out_valid  = (state == FULL);

    wb_arb2_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel(gnt1),
        .d0 (req0_data),
        .d1 (req1_data),
        .y  (sel_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= SRC_0;
            prio     <= SRC_0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                out_data <= sel_data;
                out_src  <= gnt1 ? SRC_1 : SRC_0;
                prio     <= gnt1 ? SRC_0 : SRC_1;
            end
            if (gnt0) begin
                gnt_cnt0 <= gnt_cnt0 + CNTW'(1);
            end
            if (gnt1) begin
                gnt_cnt1 <= gnt_cnt1 + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_wb_arb2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_data = '0;
    logic        req1_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_src;
    logic        out_ready = 1'b0;
    logic [7:0]  gnt_cnt0;
    logic [7:0]  gnt_cnt1;

    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    // Reference model: the output slot, the turn holder and grant tallies.
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_src;
    logic        m_turn;
    logic [7:0]  m_cnt0, m_cnt1;
    int          m_win;

    wb_arb2 #(
        .WIDTH(16),
        .CNTW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 1'b0;
        m_turn  = 1'b0;
        m_cnt0  = '0;
        m_cnt1  = '0;
    endtask

    // Who wins this cycle: -1 none, else requester index.
    function automatic int winner(input logic v0, input logic v1);
        if (m_valid && !out_ready) return -1;
        if (v0 && v1) return int'(m_turn);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".data"},  32'(out_data),  32'(m_data));
        chk({tag, ".src"},   32'(out_src),   32'(m_src));
        chk({tag, ".cnt0"},  32'(gnt_cnt0),  32'(m_cnt0));
        chk({tag, ".cnt1"},  32'(gnt_cnt1),  32'(m_cnt1));
    endtask

    // One clock: drive inputs, check handshakes before the edge, outputs after.
    task automatic cycle(input logic v0, input logic [15:0] d0,
                         input logic v1, input logic [15:0] d1,
                         input logic ordy, input string tag);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        out_ready  = ordy;
        #1;
        m_win = winner(v0, v1);
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(m_win == 0));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(m_win == 1));
        @(posedge clk);
        #1;
        if (m_win >= 0) begin
            m_valid = 1'b1;
            m_data  = (m_win == 1) ? d1 : d0;
            m_src   = (m_win == 1);
            m_turn  = (m_win == 0);
            if (m_win == 0) m_cnt0 = m_cnt0 + 8'd1;
            else            m_cnt1 = m_cnt1 + 8'd1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs(tag);
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'd0);
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with requesters asserting: ready must stay low.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        do_reset("reset");

        // Single requester 0.
        cycle(1'b1, 16'd1, 1'b0, 16'd0, 1'b1, "solo0");
        chk("solo0.exp_data", 32'(out_data), 32'd1);
        chk("solo0.exp_cnt0", 32'(gnt_cnt0), 32'd1);

        // Both valid for 4 cycles: strict alternation starting with 0.
        do_reset("reset2");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h0001, 1'b1, 16'h000F, 1'b1, "both");
            chk("both.src_seq", 32'(out_src), 32'(i % 2));
        end
        chk("both.cnt0", 32'(gnt_cnt0), 32'd2);
        chk("both.cnt1", 32'(gnt_cnt1), 32'd2);

        // Stall with 0x000F held while requester 0 toggles.
        cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, "stall");
        chk("stall.data0", 32'(out_data), 32'h000F);
        for (int i = 0; i < 3; i++) begin
            cycle(1'(i % 2 == 0), 16'(16'h1230 + i), 1'b0, 16'h0, 1'b0, "stall");
            chk("stall.hold", 32'(out_data), 32'h000F);
        end

        // Asynchronous reset between edges while FULL.
        cycle(1'b1, 16'h5A5A, 1'b0, 16'h0, 1'b1, "prefull");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.valid", 32'(out_valid), 32'd0);
        chk("async.cnt0",  32'(gnt_cnt0),  32'd0);
        chk("async.cnt1",  32'(gnt_cnt1),  32'd0);
        chk("async.data",  32'(out_data),  32'd0);
        do_reset("async");

        // 256 grants to requester 1: counter wraps to zero.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 16'h0, 1'b1, 16'(i), 1'b1, "wrap");
        end
        chk("wrap.cnt1_zero", 32'(gnt_cnt1), 32'd0);
        chk("wrap.last_data", 32'(out_data), 32'd255);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
